// File: rtl/morse_rx.sv
// Serial Morse receiver for letters A-H: synchronises the dot/dash line, frames
// each 11-bit symbol at mid-bit sample points and decodes it to a 3-bit code.
module morse_rx #(
  parameter int CLKS_PER_BIT = 250,
  parameter int CNT_BITS     = 8,
  parameter int FRAME_BITS   = 11
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       DotDashIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       FrameError,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    TAIL  = 3'd4
  } state_t;

  localparam logic [CNT_BITS-1:0] HALF      = CNT_BITS'(CLKS_PER_BIT / 2);
  localparam logic [CNT_BITS-1:0] TAIL_LOAD = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] RELOAD    = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [3:0]          REST_BITS = 4'(FRAME_BITS - 1);

  // Returns {hit, code}; hit is 0 when the frame matches no letter.
  function automatic logic [3:0] decode(input logic [FRAME_BITS-1:0] f);
    case (f)
      11'b10111000000: decode = 4'b1000;
      11'b11101010100: decode = 4'b1001;
      11'b11101011101: decode = 4'b1010;
      11'b11101010000: decode = 4'b1011;
      11'b10000000000: decode = 4'b1100;
      11'b10101110100: decode = 4'b1101;
      11'b11101110100: decode = 4'b1110;
      11'b10101010000: decode = 4'b1111;
      default:         decode = 4'b0000;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    sync1_q, s_q, samp_q;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [3:0]              bits_q, bits_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [2:0]              letter_q, letter_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;
  logic [3:0]              dec;

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      samp_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bits_q   <= '0;
      frame_q  <= '0;
      letter_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= DotDashIn;
      s_q      <= sync1_q;
      samp_q   <= s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      frame_q  <= frame_d;
      letter_q <= letter_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  // samp_q holds s one clock late: each sample point sits at E0+H+k*CLKS_PER_BIT
  // while its decision lands on the following edge, hence the H-long ALIGN count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    frame_d  = frame_q;
    letter_d = letter_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    dec      = decode(frame_q);
    case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = ALIGN;
          cnt_d   = HALF;
        end
      end
      ALIGN: begin
        if (cnt_q == '0) begin
          if (samp_q) begin
            // Start bit enters at the LSB and reaches bit 10 after the remaining shifts.
            frame_d = {{(FRAME_BITS-1){1'b0}}, 1'b1};
            bits_d  = REST_BITS;
            cnt_d   = RELOAD;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          frame_d = {frame_q[FRAME_BITS-2:0], samp_q};
          bits_d  = bits_q - 1'b1;
          cnt_d   = RELOAD;
          if (bits_q == 4'd1) state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (dec[3]) begin
          letter_d = dec[2:0];
          vld_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = TAIL_LOAD;
        state_d = TAIL;
      end
      TAIL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Letter      = letter_q;
  assign LetterValid = vld_q;
  assign FrameError  = err_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_morse_rx.sv
// Bench for morse_rx at 8 clocks per bit: timestamp-based behavioural model
// checked every cycle, plus literal timing and sequence expectations.
module tb_morse_rx;

  localparam int C = 8;
  localparam int H = C / 2;
  localparam int NCYC = 4096;

  localparam logic [10:0] CODES [0:7] = '{
    11'b10111000000, 11'b11101010100, 11'b11101011101, 11'b11101010000,
    11'b10000000000, 11'b10101110100, 11'b11101110100, 11'b10101010000
  };

  logic       clk = 1'b0;
  logic       Reset;
  logic       DotDashIn;
  logic [2:0] Letter;
  logic       LetterValid, FrameError, Busy;

  morse_rx #(.CLKS_PER_BIT(C), .CNT_BITS(4), .FRAME_BITS(11)) dut (
    .ClockIn(clk), .Reset(Reset), .DotDashIn(DotDashIn),
    .Letter(Letter), .LetterValid(LetterValid), .FrameError(FrameError), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit line_h [0:NCYC-1];
  bit rst_h  [0:NCYC-1];

  // model state: expectation for the cycle following the latest edge
  bit          m_active = 1'b0;
  int          m_e0 = 0;
  int          m_end = 0;
  logic [10:0] m_frame = '0;
  logic [2:0]  m_letter = '0;
  bit          m_vld = 1'b0;
  bit          m_err = 1'b0;

  // observed activity, used for literal checks
  int vld_cnt = 0, err_cnt = 0, busy_cnt = 0;
  int last_vld_edge = -1, last_err_edge = -1, rise_edge = -1, fall_edge = -1;
  bit prev_busy = 1'b0;
  logic [2:0] letq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %0d, expected %0d", name, cyc - 1, act, exp);
    end
  endtask

  // value of the synchronised line as seen just before edge n
  function automatic bit s_seen(input int n);
    if (n < 2) return 1'b0;
    return line_h[n-2] && !rst_h[n-1] && !rst_h[n-2];
  endfunction

  initial begin : model
    int n, rel;
    forever begin
      @(posedge clk);
      n = cyc;
      if (n < NCYC) begin
        line_h[n] = DotDashIn;
        rst_h[n]  = Reset;
      end
      m_vld = 1'b0;
      m_err = 1'b0;
      if (Reset) begin
        m_active = 1'b0;
        m_letter = '0;
      end else if (m_active) begin
        if (n == m_end) begin
          m_active = 1'b0;
        end else begin
          rel = n - m_e0 - H;
          if (rel >= 0 && rel <= 10 * C && rel % C == 0) begin
            if (rel == 0 && !s_seen(n)) m_end = n + 1;
            else m_frame = {m_frame[9:0], s_seen(n)};
          end
          if (n == m_e0 + H + 10 * C + 2) begin
            m_err = 1'b1;
            for (int k = 0; k < 8; k++) begin
              if (CODES[k] == m_frame) begin
                m_letter = 3'(k);
                m_vld = 1'b1;
                m_err = 1'b0;
              end
            end
          end
        end
      end else if (s_seen(n)) begin
        m_active = 1'b1;
        m_e0     = n;
        m_end    = n + H + 10 * C + 2 + H;
        m_frame  = '0;
      end
      cyc = cyc + 1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (Reset) begin
          check("letter_rst", Letter, 0);
          check("valid_rst", LetterValid, 0);
          check("ferr_rst", FrameError, 0);
          check("busy_rst", Busy, 0);
        end else begin
          check("letter", Letter, m_letter);
          check("valid", LetterValid, m_vld);
          check("ferr", FrameError, m_err);
          check("busy", Busy, m_active);
        end
        if (LetterValid === 1'b1) begin
          vld_cnt++;
          last_vld_edge = cyc - 1;
          letq.push_back(Letter);
        end
        if (FrameError === 1'b1) begin
          err_cnt++;
          last_err_edge = cyc - 1;
        end
        if (Busy === 1'b1) busy_cnt++;
        if (Busy === 1'b1 && !prev_busy) rise_edge = cyc - 1;
        if (Busy !== 1'b1 && prev_busy) fall_edge = cyc - 1;
        prev_busy = (Busy === 1'b1);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 10; i >= 0; i--) begin
      DotDashIn = f[i];
      tick(C);
    end
    DotDashIn = 1'b0;
  endtask

  initial begin : stim
    int r0, t, v0, e0, b0;
    logic [10:0] f;
    Reset = 1'b1;
    DotDashIn = 1'b1;
    tick(3);
    r0 = cyc;
    Reset = 1'b0;
    tick(4);
    DotDashIn = 1'b0;
    tick(10);
    check("reset_busy_rise_edge", rise_edge, r0 + 2);
    check("reset_glitch_no_pulse", vld_cnt + err_cnt, 0);

    // single letter 010
    v0 = vld_cnt; e0 = err_cnt; t = cyc;
    send_frame(11'b11101011101);
    tick(3 * C);
    check("single_pulse_edge", last_vld_edge, t + 88);
    check("single_letter", Letter, 3'b010);
    check("single_vld_count", vld_cnt - v0, 1);
    check("single_no_ferr", err_cnt - e0, 0);
    check("single_idle_edge", fall_edge, t + 92);

    // all eight letters back to back
    letq.delete();
    v0 = vld_cnt; e0 = err_cnt;
    for (int k = 0; k < 8; k++) begin
      send_frame(CODES[k]);
      tick(3 * C);
    end
    check("all_vld_count", vld_cnt - v0, 8);
    check("all_no_ferr", err_cnt - e0, 0);
    for (int k = 0; k < 8; k++) begin
      if (k < letq.size()) check("all_letter_seq", letq[k], k);
      else check("all_letter_missing", 32'hFFFF_FFFF, k);
    end

    // invalid frame after a valid 101
    send_frame(11'b10101110100);
    tick(3 * C);
    v0 = vld_cnt; e0 = err_cnt; t = cyc;
    send_frame(11'b11111111111);
    tick(3 * C);
    check("inv_ferr_count", err_cnt - e0, 1);
    check("inv_ferr_edge", last_err_edge, t + 88);
    check("inv_no_vld", vld_cnt - v0, 0);
    check("inv_letter_held", Letter, 3'b101);

    // one-clock glitch
    v0 = vld_cnt; e0 = err_cnt; b0 = busy_cnt;
    DotDashIn = 1'b1;
    tick(1);
    DotDashIn = 1'b0;
    tick(20);
    check("glitch_busy_cycles", busy_cnt - b0, 5);
    check("glitch_no_pulse", (vld_cnt - v0) + (err_cnt - e0), 0);
    check("glitch_idle", Busy, 0);

    // reset during bit 5 of 110, then a clean 011
    v0 = vld_cnt; e0 = err_cnt;
    f = 11'b11101110100;
    for (int i = 10; i >= 6; i--) begin
      DotDashIn = f[i];
      tick(C);
    end
    DotDashIn = f[5];
    tick(3);
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    DotDashIn = 1'b0;
    tick(2 * C);
    check("abort_no_pulse", (vld_cnt - v0) + (err_cnt - e0), 0);
    check("abort_letter_cleared", Letter, 3'b000);
    send_frame(11'b11101010000);
    tick(3 * C);
    check("after_abort_vld_count", vld_cnt - v0, 1);
    check("after_abort_no_ferr", err_cnt - e0, 0);
    check("after_abort_letter", Letter, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/morse_rx.md
# morse_rx

Serial Morse receiver for the 3-bit letter set (A–H). Samples the serial dot/dash line produced by the lab's Morse transmitter, frames each 11-bit symbol, and decodes it back to a 3-bit letter code with a one-cycle valid or error pulse. It sits on the same clock as the transmitter and is the loop-back partner for transmitter bring-up.

## Interface
- CLKS_PER_BIT, 250: clocks per Morse bit; must match the transmitter rate; ≥4.
- CNT_BITS, 8: width of the bit-timing counter; must hold CLKS_PER_BIT-1.
- FRAME_BITS, 11: bits per symbol, MSB first.
- ClockIn  input  1  single system clock; all logic on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DotDashIn  input  1  serial Morse line; idle low; every valid symbol starts with 1.
- Letter  output  3  last decoded letter code; holds until the next valid decode.
- LetterValid  output  1  one-cycle pulse when Letter has just been updated.
- FrameError  output  1  one-cycle pulse when a complete frame matches no code.
- Busy  output  1  high whenever the state is not IDLE.

## Operation
- Input synchroniser: two flops, DotDashIn → s; reset to 0. All decisions use s.
- Half-bit count H = floor(CLKS_PER_BIT/2).
- Code table, frame bits [10:0] MSB first:
  - 000 = 10111000000
  - 001 = 11101010100
  - 010 = 11101011101
  - 011 = 11101010000
  - 100 = 10000000000
  - 101 = 10101110100
  - 110 = 11101110100
  - 111 = 10101010000
- States:
  - IDLE: Busy=0. On s=1, go to ALIGN with count=H-1.
  - ALIGN: count down. At count=0, sample s.
    - s=0: glitch; return to IDLE with no pulse.
    - s=1: shift it into the frame register as bit 10, set bitsLeft=10, count=CLKS_PER_BIT-1, go to SHIFT.
  - SHIFT: count down. At count=0, shift s into the frame LSB, decrement bitsLeft, and reload count. Go to DONE on the edge that samples the final bit (bitsLeft 1→0).
  - DONE: one cycle. Compare the frame register with all 8 codes.
    - Match: register Letter=code and LetterValid=1.
    - No match: register FrameError=1; Letter unchanged.
    - Then go to TAIL with count=H-1.
  - TAIL: count down to 0, then go to IDLE. This covers the remaining half of the last bit, so a trailing 1 cannot false-start.
- LetterValid and FrameError are never high together, and each is high for exactly one cycle per frame.
- DotDashIn changes during ALIGN, SHIFT or TAIL are ignored except at sample points. There is no re-synchronisation mid-frame.
- Reset, including mid-frame:
  - State returns to IDLE; synchroniser, frame register and counters clear.
  - Letter=000; LetterValid=FrameError=Busy=0.
  - A partial frame is discarded with no pulse.

## Timing
- E0 is the edge on which IDLE sees s=1. s is DotDashIn delayed 2 clocks.
- Bit 10 is sampled at E0+H.
- Bit i is sampled at E0+H+(10−i)·CLKS_PER_BIT.
- DONE occupies the cycle after the bit-0 sample.
- LetterValid/FrameError are high in the single cycle starting at E0+H+10·CLKS_PER_BIT+2.
- Return to IDLE at E0+H+10·CLKS_PER_BIT+2+H. Busy is high from E0 up to that edge.
- For a transmitter line rising at edge T, E0=T+2. The minimum inter-frame gap accepted is 0 extra clocks after the transmitter's 11th bit ends.
- Defaults (CLKS_PER_BIT=250, H=125): decode pulse at E0+2627.
- Bench setting (CLKS_PER_BIT=8, H=4): decode pulse at E0+86, IDLE at E0+90.

## Test plan
- **Reset values:** assert Reset for 3 cycles with DotDashIn=1 → Letter=000, LetterValid=0, FrameError=0, Busy=0. After release with DotDashIn=1, Busy rises 3 edges later.
- **Single letter (CLKS_PER_BIT=8):** drive code 010 (11101011101), 8 clocks per bit, from edge T → LetterValid high only in cycle T+88, Letter=010, FrameError never high.
- **All letters:** all 8 codes back-to-back, each followed by a 3-bit low gap → 8 LetterValid pulses; Letter sequence 000…111; no FrameError.
- **Invalid frame:** 11111111111 after a valid 101 frame → FrameError pulse at the DONE+1 cycle; Letter stays 101; LetterValid stays 0.
- **Glitch:** DotDashIn high for 1 clock, then low → Busy high for H+1 cycles; no LetterValid or FrameError; back to IDLE.
- **Mid-frame reset:** assert Reset during bit 5 of code 110, release, then send code 011 → no pulse for the aborted frame; Letter=011 with exactly one LetterValid.
